// File: rtl/sobel_pkg.sv
// Shared types for the 3x3 Sobel pipeline: pixel type and the nine-pixel window
// handed from the neighbourhood generator to the gradient stage.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t p0;
    pix_t p1;
    pix_t p2;
    pix_t p3;
    pix_t p4;
    pix_t p5;
    pix_t p6;
    pix_t p7;
    pix_t p8;
  } win3_t;

  // Width of a counter/address that must reach n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// One image line of pixel storage: combinational read and synchronous write
// at the same address, so a read in the write cycle returns the old contents.
module sobel_linebuf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pix_t          wdata_i,
  output pix_t          rdata_o
);

  // Contents are deliberately unreset; no window exposes them before two full lines land.
  pix_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window3.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel gradient stage.
// Optional macro SOBEL_WIN_SIDEBAND_EN adds registered out_sof/out_eol outputs.
module sobel_window3
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  pix_t in_pix,
  input  logic in_valid,
  input  logic in_sof,
  output logic in_ready,
  output pix_t p0,
  output pix_t p1,
  output pix_t p2,
  output pix_t p3,
  output pix_t p4,
  output pix_t p5,
  output pix_t p6,
  output pix_t p7,
  output pix_t p8,
  output logic out_valid,
  input  logic out_ready
`ifdef SOBEL_WIN_SIDEBAND_EN
  ,
  output logic out_sof,
  output logic out_eol
`endif
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Handshake: a beat transfers on a rising clk edge when valid && ready are both
  // high; the window is held stable while out_valid && !out_ready.
  logic          accept;
  logic          qualify;
  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  win3_t         win_q, win_d;
  logic          out_valid_q, out_valid_d;
  pix_t          lb0_rd, lb1_rd;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame beat is position (0,0) no matter where the counters were.
  assign pos_col = in_sof ? '0 : col_q;
  assign pos_row = in_sof ? '0 : row_q;
  assign qualify = (pos_row >= RW'(2)) && (pos_col >= CW'(2));

  sobel_linebuf #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
    .clk    (clk),
    .we_i   (accept),
    .addr_i (pos_col),
    .wdata_i(in_pix),
    .rdata_o(lb0_rd)
  );

  sobel_linebuf #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk    (clk),
    .we_i   (accept),
    .addr_i (pos_col),
    .wdata_i(lb0_rd),
    .rdata_o(lb1_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      win_d.p0 = win_q.p1;
      win_d.p1 = win_q.p2;
      win_d.p2 = lb1_rd;
      win_d.p3 = win_q.p4;
      win_d.p4 = win_q.p5;
      win_d.p5 = lb0_rd;
      win_d.p6 = win_q.p7;
      win_d.p7 = win_q.p8;
      win_d.p8 = in_pix;
      out_valid_d = qualify;
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p0 = win_q.p0;
  assign p1 = win_q.p1;
  assign p2 = win_q.p2;
  assign p3 = win_q.p3;
  assign p4 = win_q.p4;
  assign p5 = win_q.p5;
  assign p6 = win_q.p6;
  assign p7 = win_q.p7;
  assign p8 = win_q.p8;

`ifdef SOBEL_WIN_SIDEBAND_EN
  logic out_sof_q, out_eol_q;

  // Sideband travels with the window, so it only changes on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sof_q <= 1'b0;
      out_eol_q <= 1'b0;
    end else if (accept) begin
      out_sof_q <= (pos_row == RW'(2)) && (pos_col == CW'(2));
      out_eol_q <= (pos_col == COL_LAST);
    end
  end

  assign out_sof = out_sof_q;
  assign out_eol = out_eol_q;
`endif

endmodule

// File: doc/sobel_window3.md
# sobel_window3

Streaming 3x3 neighbourhood generator placed directly upstream of the 3x3 Sobel gradient stage. It accepts one 8-bit pixel per accepted beat in raster order and buffers the two previous image lines. For every interior pixel it presents the full registered window p0..p8 with a valid/ready handshake. Border pixels (first two rows, first two columns of each row) produce no window.

## Interface

- IMG_WIDTH, 640: pixels per line; must be ≥ 3.
- IMG_HEIGHT, 480: lines per frame; must be ≥ 3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_pix  in  8  input pixel.
- in_valid  in  1  in_pix is valid.
- in_sof  in  1  marks the first pixel of a frame; sampled only on an accepted beat.
- in_ready  out  1  block can accept a pixel this cycle.
- p0..p8  out  8 each  window pixels:
  - p0 p1 p2: row y-2, columns x-2, x-1, x.
  - p3 p4 p5: row y-1, same columns.
  - p6 p7 p8: row y, same columns.
  - p8 is the newest pixel.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_sof, out_eol  out  1 each  present only with SOBEL_WIN_SIDEBAND_EN.

## Operation

**Acceptance and handshake**
- Accept when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). The window is never overwritten while it is held.

**On accept at position (row, col)**
- Read lb0[col] (row y-1) and lb1[col] (row y-2).
- Shift each column register left: p0←p1←p2←lb1[col]; p3←p4←p5←lb0[col]; p6←p7←p8←in_pix.
- Write lb1[col]←old lb0[col] and lb0[col]←in_pix. Reads use pre-write data.

**Position counters**
- col counts 0..IMG_WIDTH-1. row counts 0..IMG_HEIGHT-1.
- col wraps to 0 and increments row. After (IMG_HEIGHT-1, IMG_WIDTH-1) both return to 0.
- An accepted beat with in_sof=1 is treated as position (0,0) regardless of the counters. Counters then continue from (0,1).

**Window valid**
- out_valid is set on an accept where row ≥ 2 && col ≥ 2, using the pixel's own position.
- out_valid clears on out_ready when no new qualifying accept occurs in that cycle.
- Accept and out_ready in the same cycle: the window is replaced and out_valid stays 1 if the new position qualifies.

**Widths**
- Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). Comparisons are unsigned.
- No arithmetic on pixel data.

**Reset**
- All p outputs 0. out_valid, out_sof, out_eol 0. Counters 0.
- Line-buffer contents are not reset. Stale data is never exposed, because no window is emitted until two full lines are written.

**Mid-frame events**
- Reset mid-frame discards the frame. The next pixel is position (0,0).
- in_sof mid-frame restarts at (0,0). No windows are emitted until row 2 of the new frame.

## Timing

- Latency: 1 cycle from an accepted pixel to its window on p0..p8 / out_valid.
- Throughput: 1 pixel/cycle when out_ready=1.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Line-buffer reads are combinational (distributed RAM / registers).
- The only combinational input-to-output path is out_ready → in_ready.

## Configuration

- SOBEL_WIN_SIDEBAND_EN defined: adds registered outputs out_sof and out_eol, updated with the window.
  - out_sof=1 on the window whose p8 is at position (2,2).
  - out_eol=1 on the window whose p8 is at col = IMG_WIDTH-1.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure

- Shared package sobel_pkg holds:
  - PIX_W = 8;
  - typedef pix_t (logic [7:0]);
  - typedef win3_t (struct of nine pix_t, p0..p8), shared with the Sobel stage.
- One sub-module, sobel_linebuf: IMG_WIDTH x 8 memory with combinational read and synchronous write at the same address. Instantiated twice (lb0, lb1).
- Counters, shift registers and handshake live in the top module.

## Test plan

- Ramp frame: IMG_WIDTH=4, IMG_HEIGHT=4, pixel = 16*row+col, in_valid=1, out_ready=1.
  - Exactly 4 windows.
  - First window: p0..p8 = 00,01,02,10,11,12,20,21,22, one cycle after pixel 0x22 is accepted.
  - Last window has p8=0x33.
- Backpressure: same frame with out_ready=0 for 5 cycles at the first window.
  - in_ready=0 and p0..p8 hold 00..22 throughout.
  - On release, the windows resume in order with none lost or duplicated.
- Back-to-back frames (second frame pixel = 0x80+16*row+col, in_sof on its first pixel).
  - No window is emitted for second-frame rows 0–1.
  - First new window has p0=0x80, p8=0xA2.
- Mid-frame in_sof: assert in_sof at frame-1 position (2,1).
  - No out_valid until 10 more pixels (rows 0–1 plus 2 of row 2).
- Reset: rst_n low mid-frame, outputs checked while in reset.
  - Outputs are 0 immediately, asynchronously.
  - After release, the ramp frame reproduces the first test exactly.
- With SOBEL_WIN_SIDEBAND_EN:
  - out_sof=1 only on the first window of each frame.
  - out_eol=1 on the 2nd and 4th windows of the 4x4 frame.
